// File: rtl/tnn_feature_sequencer.sv
// Streaming front-end for the 2-bit six-input classifiers: quantizes raw samples into a
// six-slot frame, drives the classifier, and returns its class through a valid/ready port.
module tnn_feature_sequencer #(
    parameter int          RAW_W = 8,
    parameter int unsigned T1    = 64,
    parameter int unsigned T2    = 128,
    parameter int unsigned T3    = 192,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RAW_W-1:0] s_data,
    input  logic             s_last,
    output logic [1:0]       feat_a,
    output logic [1:0]       feat_b,
    output logic [1:0]       feat_c,
    output logic [1:0]       feat_d,
    output logic [1:0]       feat_e,
    output logic [1:0]       feat_f,
    input  logic             cls_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_class,
    output logic             m_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [RAW_W-1:0] T1_V = RAW_W'(T1);
    localparam logic [RAW_W-1:0] T2_V = RAW_W'(T2);
    localparam logic [RAW_W-1:0] T3_V = RAW_W'(T3);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        EVAL  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] idx;
    logic       drain_pend;
    logic       err_flag;
    logic [1:0] feat [6];

    function automatic logic [1:0] quantize(input logic [RAW_W-1:0] x);
        if (x >= T3_V)      return 2'd3;
        else if (x >= T2_V) return 2'd2;
        else if (x >= T1_V) return 2'd1;
        else                return 2'd0;
    endfunction

    // Handshake strobes depend on state only, so no input reaches them combinationally.
    assign s_ready = (state == LOAD) || (state == DRAIN);
    assign m_valid = (state == HOLD);

    assign feat_a = feat[0];
    assign feat_b = feat[1];
    assign feat_c = feat[2];
    assign feat_d = feat[3];
    assign feat_e = feat[4];
    assign feat_f = feat[5];

    // NOTE: all state updates use non-blocking assignments so that every register samples
    // pre-edge values; the feature slots are a handful of flops, so they are reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            idx        <= 3'd0;
            drain_pend <= 1'b0;
            err_flag   <= 1'b0;
            m_class    <= 1'b0;
            m_err      <= 1'b0;
            frame_cnt  <= '0;
            for (int i = 0; i < 6; i++) feat[i] <= 2'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        // The first beat of a frame wipes the older slots; its own slot is written below.
                        if (idx == 3'd0) begin
                            for (int i = 1; i < 6; i++) feat[i] <= 2'd0;
                        end
                        feat[idx] <= quantize(s_data);
                        if (s_last || idx == 3'd5) begin
                            state      <= EVAL;
                            idx        <= 3'd0;
                            err_flag   <= !(s_last && idx == 3'd5);
                            drain_pend <= !s_last;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                EVAL: begin
                    m_class <= cls_in;
                    m_err   <= err_flag;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (m_ready) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        state     <= drain_pend ? DRAIN : LOAD;
                    end
                end
                DRAIN: begin
                    // Overlong frame tail: swallow beats until the producer marks the end.
                    if (s_valid && s_last) begin
                        drain_pend <= 1'b0;
                        state      <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_feature_sequencer.sv
// Self-checking bench for tnn_feature_sequencer: directed frames plus randomized frames
// against a frame-level reference model and a behavioural classifier.
module tb_tnn_feature_sequencer;

    localparam int RAW_W = 8;
    localparam int T1 = 64;
    localparam int T2 = 128;
    localparam int T3 = 192;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [RAW_W-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic [1:0]       feat_a, feat_b, feat_c, feat_d, feat_e, feat_f;
    logic             cls_in;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_class;
    logic             m_err;
    logic [CNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int frame_data [8];

    always #5 clk = ~clk;

    // Classifier stand-in: class 1 iff a+c > b+d+e+f.
    assign cls_in = (int'(feat_a) + int'(feat_c)) >
                    (int'(feat_b) + int'(feat_d) + int'(feat_e) + int'(feat_f));

    tnn_feature_sequencer #(
        .RAW_W(RAW_W), .T1(T1), .T2(T2), .T3(T3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .feat_a(feat_a), .feat_b(feat_b), .feat_c(feat_c),
        .feat_d(feat_d), .feat_e(feat_e), .feat_f(feat_f),
        .cls_in(cls_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err),
        .frame_cnt(frame_cnt)
    );

    function automatic int quant(input int x);
        if (x >= T3) return 3;
        if (x >= T2) return 2;
        if (x >= T1) return 1;
        return 0;
    endfunction

    function automatic logic [11:0] obs_feats();
        return {feat_a, feat_b, feat_c, feat_d, feat_e, feat_f};
    endfunction

    // One beat; returns at the negedge after the transferring edge.
    task automatic send_beat(input int d, input logic last);
        int waited;
        s_valid = 1'b1;
        s_data  = RAW_W'(d);
        s_last  = last;
        waited  = 0;
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL beat_wait: s_ready=%0b after %0d cycles, required 1", s_ready, waited);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Sends frame_data[0..n-1] (s_last on beat n), holds the result for `hold` cycles.
    task automatic run_frame(input string name, input int n, input int hold);
        int exp_f [6];
        logic [11:0] exp_pk;
        logic exp_cls;
        logic exp_err;
        int nload;
        nload = (n > 6) ? 6 : n;
        for (int k = 0; k < 6; k++) exp_f[k] = (k < nload) ? quant(frame_data[k]) : 0;
        exp_pk  = {2'(exp_f[0]), 2'(exp_f[1]), 2'(exp_f[2]), 2'(exp_f[3]), 2'(exp_f[4]), 2'(exp_f[5])};
        exp_cls = (exp_f[0] + exp_f[2]) > (exp_f[1] + exp_f[3] + exp_f[4] + exp_f[5]);
        exp_err = (n != 6);

        for (int k = 0; k < nload; k++) send_beat(frame_data[k], k == n - 1);

        // EVAL cycle
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s eval: m_valid=%0b s_ready=%0b, required 0 0", name, m_valid, s_ready);
        end
        checks++;
        if (obs_feats() !== exp_pk) begin
            errors++;
            $display("FAIL %s feats: got %h required %h", name, obs_feats(), exp_pk);
        end
        @(negedge clk);

        // HOLD, with back-pressure
        for (int c = 0; c <= hold; c++) begin
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_class !== exp_cls || m_err !== exp_err ||
                obs_feats() !== exp_pk || frame_cnt !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL %s hold[%0d]: v=%0b rdy=%0b cls=%0b err=%0b f=%h cnt=%0d required 1 0 %0b %0b %h %0d",
                         name, c, m_valid, s_ready, m_class, m_err, obs_feats(), frame_cnt,
                         exp_cls, exp_err, exp_pk, exp_cnt);
            end
            if (c < hold) @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== CNT_W'(exp_cnt)) begin
            errors++;
            $display("FAIL %s handshake: v=%0b rdy=%0b cnt=%0d required 0 1 %0d",
                     name, m_valid, s_ready, frame_cnt, exp_cnt);
        end

        // Tail of an overlong frame is drained without touching the features.
        for (int k = 6; k < n; k++) begin
            send_beat(frame_data[k], k == n - 1);
            checks++;
            if (obs_feats() !== exp_pk || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s drain[%0d]: f=%h v=%0b required %h 0", name, k, obs_feats(), m_valid, exp_pk);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (obs_feats() !== 12'h000 || m_valid !== 1'b0 || m_class !== 1'b0 || m_err !== 1'b0 ||
            frame_cnt !== '0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: f=%h v=%0b cls=%0b err=%0b cnt=%0d rdy=%0b required 000 0 0 0 0 1",
                     name, obs_feats(), m_valid, m_class, m_err, frame_cnt, s_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
        exp_cnt = 0;
    endtask

    task automatic test_nominal();
        frame_data = '{200, 10, 130, 70, 0, 255, 0, 0};
        run_frame("nominal", 6, 0);
    endtask

    task automatic test_thresholds();
        frame_data = '{63, 64, 127, 128, 191, 192, 0, 0};
        run_frame("thresholds", 6, 1);
    endtask

    task automatic test_short();
        frame_data = '{250, 250, 250, 0, 0, 0, 0, 0};
        run_frame("short", 3, 0);
        frame_data = '{5, 0, 0, 0, 0, 0, 0, 0};
        run_frame("single", 1, 0);
    endtask

    task automatic test_long();
        frame_data = '{255, 0, 255, 0, 0, 0, 255, 255};
        run_frame("long", 8, 0);
        frame_data = '{0, 200, 64, 130, 10, 63, 0, 0};
        run_frame("after_long", 6, 0);
    endtask

    task automatic test_backpressure();
        frame_data = '{192, 0, 192, 0, 0, 64, 0, 0};
        run_frame("backpressure", 6, 10);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < 8; k++) frame_data[k] = $urandom_range(0, 255);
            run_frame($sformatf("rand%0d", f), n, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_frame();
        send_beat(220, 1'b0);
        send_beat(100, 1'b0);
        send_beat(70, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'd99;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_frame");
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        check_reset_outputs("reset_mid_release");
        frame_data = '{200, 10, 130, 70, 0, 255, 0, 0};
        run_frame("post_reset", 6, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_thresholds();
        test_short();
        test_long();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnn_feature_sequencer.md
# tnn_feature_sequencer

Streaming front-end and result collector for the 2-bit, six-input approximate classifiers (breastcancer2b family). It accepts raw feature samples one beat at a time, quantizes each to 2 bits and assembles one frame of six features. It drives the features to the combinational classifier's `input_a..input_f`, samples the 1-bit `cgp_out` and returns the class through a valid/ready result port. It is the driving and consuming end of the classifier's interface.

## Interface
- `RAW_W`, 8: raw feature width.
- `T1`, 64: quantization threshold for level 1 (unsigned, RAW_W bits).
- `T2`, 128: threshold for level 2.
- `T3`, 192: threshold for level 3. Requires T1 ≤ T2 ≤ T3.
- `CNT_W`, 16: frame counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  raw sample valid.
- `s_ready`  out  1  sequencer accepts a sample.
- `s_data`  in  RAW_W  raw feature, unsigned.
- `s_last`  in  1  marks the final (6th) feature of a frame.
- `feat_a` … `feat_f`  out  2 each  registered quantized features, wired to classifier `input_a..input_f`.
- `cls_in`  in  1  classifier `cgp_out`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumer ready.
- `m_class`  out  1  classification result.
- `m_err`  out  1  frame had a length error.
- `frame_cnt`  out  CNT_W  count of results delivered.

## Operation
- Quantization: q = 3 if x ≥ T3; else 2 if x ≥ T2; else 1 if x ≥ T1; else 0.
- A beat transfers when `s_valid & s_ready`. Beat k of a frame (k = 0..5) writes slot k (a..f).
- Accepting beat 0 also clears slots b..f to 0. Slots not received in the frame therefore read 0.
- FSM states:
  - LOAD: `s_ready`=1, slot index `idx` counts 0..5.
    - Transfer with `s_last` and idx<5 (short frame): go to EVAL, error flag set, idx←0.
    - Transfer with idx==5 and `s_last`: go to EVAL, error flag clear, idx←0.
    - Transfer with idx==5 and no `s_last` (long frame): go to EVAL, error flag set, drain pending.
  - EVAL: one cycle, `s_ready`=0. Features are stable. `cls_in` is sampled into `m_class` at the end of the cycle, and the error flag is copied to `m_err`. Next state is HOLD.
  - HOLD: `m_valid`=1, `s_ready`=0. On `m_ready`: `frame_cnt`+1 (wraps modulo 2^CNT_W). Next state is DRAIN if drain pending, otherwise LOAD.
  - DRAIN: `s_ready`=1. Beats are accepted and discarded, and features are not written. A transfer with `s_last` clears drain pending and returns to LOAD.
- `m_class` and `m_err` hold their values until the next EVAL.
- `s_last` is ignored outside LOAD and DRAIN.

## Timing
- Reset (async assert, sync-released state) sets:
  - state LOAD, idx 0, drain pending 0, error flag 0;
  - `feat_a..f`=0, `m_valid`=0, `m_class`=0, `m_err`=0, `frame_cnt`=0.
  - `s_ready`=1 from the first cycle after reset release.
- `s_ready` and `m_valid` are decoded combinationally from state only. There is no input-to-output combinational path on the handshake.
- Latency: final beat accepted at edge N → EVAL during cycle N..N+1 → `m_valid`=1 after edge N+1.
- Classifier settle budget is one full clock period: features change at edge N and `cls_in` is sampled at edge N+1.
- Throughput: 6 beats + EVAL + at least 1 HOLD cycle = 8 cycles per frame minimum. There is no overlap of frames.
- Back-pressure: `m_valid` stays asserted and `m_class`, `m_err` and `feat_*` stay stable while `m_ready`=0, for any number of cycles.
- Reset mid-frame or mid-HOLD: the partial frame and any pending result are discarded. No result is emitted and `frame_cnt` is not incremented.

## Test plan
- Nominal frame: raw 200,10,130,70,0,255 with `s_last` on beat 6; `cls_in` from a bench model returning 1 iff a+c > b+d+e+f.
  - Required: feat a..f = 3,0,2,1,0,3.
  - `m_valid` asserts 2 edges after the last beat with `m_class`=1, `m_err`=0.
  - `frame_cnt` goes 0→1 on handshake.
- Threshold edges: raw 63,64,127,128,191,192 → feat = 0,1,1,2,2,3.
- Short frame: 3 beats (250,250,250) with `s_last` on beat 3.
  - Required: feat = 3,3,3,0,0,0 and `m_err`=1.
  - `m_class` equals the `cls_in` value sampled in EVAL.
- Long frame: 8 beats with `s_last` on beat 8.
  - Required: result after beat 6 with `m_err`=1.
  - Beats 7–8 are accepted in DRAIN and do not alter `feat_*`.
  - The next frame then classifies normally with `m_err`=0.
- Back-pressure: hold `m_ready`=0 for 10 cycles. `m_valid` and `m_class` stay stable, `s_ready`=0 throughout, and `frame_cnt` increments exactly once.
- Reset during beat 4 of a frame: all outputs return to reset values, `s_ready`=1 after release, and a following full frame yields a correct result with `frame_cnt`=1.
